rr_arb_4_enc: RTL and testbench
===============================

RR_ARB_4_ENC -- requirements
Module: rr_arb_4_enc

Purpose: 4-requester round-robin arbiter producing the 2-bit encoded grant index that drives the downstream 2x4 decoder select input.

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 8, giving the maximum grant hold in cycles while other requests wait; it is used only when RR_ARB_TIMEOUT_EN is defined; legal range 2..255.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port req, input, 4 bits: request per requester, bit n = requester n, level-sensitive.
REQ-005 The block SHALL have port gnt_idx, output, 2 bits: index of the granted requester, registered, feeding the decoder select.
REQ-006 The block SHALL have port gnt_valid, output, 1 bit: high when gnt_idx holds a live grant, registered.
REQ-007 The block SHALL have port ptr, output, 2 bits: current round-robin priority pointer, registered, for debug and verification.

Function
REQ-008 The FSM SHALL have two states: IDLE (gnt_valid=0) and GRANT (gnt_valid=1).
REQ-009 Selection SHALL pick the first set req bit scanning ptr, ptr+1, ptr+2, ptr+3, modulo 4.
REQ-010 In IDLE, on an edge with req!=0, the FSM SHALL go to GRANT with gnt_idx=selected: 1-cycle latency from req sampled to gnt_valid high.
REQ-011 In GRANT, while req[gnt_idx]=1 and no timeout fires, gnt_idx SHALL hold unchanged.
REQ-012 In GRANT, on an edge with req[gnt_idx]=0, ptr SHALL become gnt_idx+1 mod 4; if any other req bit is set, the FSM SHALL grant the next selection by the new ptr on that same edge with no idle cycle; otherwise it SHALL go to IDLE.
REQ-013 ptr SHALL change only when a grant ends: requester release or timeout.
REQ-014 gnt_idx SHALL hold its last value in IDLE; the decoder consumer SHALL qualify it with gnt_valid.
REQ-015 A requester that drops and re-raises req in the same cycle its grant ends SHALL be treated as new and served after the other pending requesters, per REQ-012.
REQ-016 Pointer and index arithmetic SHALL be 2-bit modulo 4: 3+1 wraps to 0.
REQ-017 With req=4'b0000 in IDLE, the FSM SHALL stay in IDLE with outputs unchanged.

Reset
REQ-018 Asserting rst SHALL immediately, without waiting for clk, force state=IDLE, gnt_valid=0, gnt_idx=2'b00, ptr=2'b00, and hold counter=0.
REQ-019 Reset asserted mid-grant SHALL abort the grant; after rst deasserts, arbitration SHALL restart from ptr=0 on the first rising edge.

Configuration
REQ-020 Macro RR_ARB_TIMEOUT_EN SHALL compile in a hold counter that increments each GRANT cycle and clears on every new grant.
REQ-021 With RR_ARB_TIMEOUT_EN defined, on an edge where the counter equals TIMEOUT_CYCLES-1 and another req bit is set, the grant SHALL be forcibly ended as in REQ-012, even with req[gnt_idx]=1.
REQ-022 With RR_ARB_TIMEOUT_EN defined and no other request pending, the counter SHALL saturate at TIMEOUT_CYCLES-1 and the grant SHALL be held.
REQ-023 Without RR_ARB_TIMEOUT_EN, no counter SHALL exist, a grant SHALL last until release, and TIMEOUT_CYCLES SHALL be ignored.

Verification
REQ-024 Reset check: rst=1 mid-grant with gnt_idx=2 -> gnt_valid=0, gnt_idx=0, ptr=0 before the next clk edge.
REQ-025 Single request: req=4'b0100 from IDLE -> next edge gnt_valid=1, gnt_idx=2; drop req -> next edge gnt_valid=0, ptr=3.
REQ-026 Rotation: req=4'b1111 held, each requester releasing after 1 grant cycle then re-raising -> gnt_idx sequence 0,1,2,3,0, with no gnt_valid gap.
REQ-027 Wrap: ptr=3, req=4'b1001 -> gnt_idx=3; on release -> gnt_idx=0 on the same edge, ptr=0.
REQ-028 Timeout (macro on, TIMEOUT_CYCLES=8): req=4'b0011 held continuously -> gnt_idx=0 for exactly 8 cycles, then 1 for 8 cycles, then 0.
REQ-029 Timeout saturation (macro on): req=4'b0001 held for 20 cycles -> gnt_idx=0 throughout, no gnt_valid drop; macro off: req=4'b0011 held -> gnt_idx=0 indefinitely.

Source files
------------

// File: rtl/rr_arb_4_enc.sv
// rr_arb_4_enc: 4-requester round-robin arbiter with a 2-bit encoded grant
// index for a downstream 2x4 decoder select. The grant is held until the
// owner drops its request; the pointer then advances past the owner.
// Optional feature: define RR_ARB_TIMEOUT_EN to add a hold counter that
// forcibly ends a grant after TIMEOUT_CYCLES cycles when others are waiting.
module rr_arb_4_enc #(
   parameter int TIMEOUT_CYCLES = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] req,
   output logic [1:0] gnt_idx,
   output logic       gnt_valid,
   output logic [1:0] ptr
);

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   state_t     state;
   state_t     state_nxt;
   logic [1:0] idx_nxt;
   logic [1:0] ptr_nxt;
   logic [3:0] others;
   logic [3:0] scan_req;
   logic [1:0] scan_base;
   logic       sel_found;
   logic [1:0] sel_idx;
   logic       timeout_hit;
   logic       end_grant;

   // Returns {found, index} of the first set bit scanning base, base+1, ...
   // modulo 4; the descending loop lets the lowest offset win.
   function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] base);
      logic [1:0] j;
      rr_pick = 3'b000;
      for (int k = 3; k >= 0; k--) begin
         j = base + 2'(k);
         if (r[j]) rr_pick = {1'b1, j};
      end
   endfunction

   // Requests other than the current owner; a grant that ends never
   // re-selects its own requester on the same edge.
   assign others = req & ~(4'b0001 << gnt_idx);

`ifdef RR_ARB_TIMEOUT_EN
   logic [7:0] hold_cnt;

   assign timeout_hit = (hold_cnt == 8'(TIMEOUT_CYCLES - 1)) && (others != 4'b0000);

   // Hold counter: clears on every new grant, counts GRANT cycles, saturates.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold_cnt <= 8'd0;
      end else if (state_nxt == GRANT && (state == IDLE || end_grant)) begin
         hold_cnt <= 8'd0;
      end else if (state == GRANT && hold_cnt != 8'(TIMEOUT_CYCLES - 1)) begin
         hold_cnt <= hold_cnt + 8'd1;
      end
   end
`else
   logic [7:0] unused_timeout_cfg;

   assign unused_timeout_cfg = 8'(TIMEOUT_CYCLES);
   assign timeout_hit        = 1'b0;
`endif

   assign end_grant = (state == GRANT) && (!req[gnt_idx] || timeout_hit);

   // Scan from ptr when idle; when a grant ends, scan from the post-grant
   // pointer so the hand-off happens on the same edge.
   assign scan_base = (state == GRANT) ? (gnt_idx + 2'd1) : ptr;
   assign scan_req  = (state == GRANT) ? others : req;
   assign {sel_found, sel_idx} = rr_pick(scan_req, scan_base);

   // State, grant index and pointer registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         gnt_idx <= 2'b00;
         ptr     <= 2'b00;
      end else begin
         state   <= state_nxt;
         gnt_idx <= idx_nxt;
         ptr     <= ptr_nxt;
      end
   end

   // Next-state logic: grant from idle, hold, or hand off when a grant ends.
   always_comb begin
      state_nxt = state;
      idx_nxt   = gnt_idx;
      ptr_nxt   = ptr;
      case (state)
         IDLE: begin
            if (sel_found) begin
               state_nxt = GRANT;
               idx_nxt   = sel_idx;
            end
         end
         GRANT: begin
            if (end_grant) begin
               ptr_nxt = gnt_idx + 2'd1;
               if (sel_found) begin
                  idx_nxt = sel_idx;
               end else begin
                  state_nxt = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign gnt_valid = (state == GRANT);

endmodule

// File: tb/tb_rr_arb_4_enc.sv
// tb_rr_arb_4_enc: directed literal checks plus randomized requests compared
// cycle by cycle against a behavioural round-robin model.
module tb_rr_arb_4_enc;

   localparam int T = 8;

   logic       clk;
   logic       rst;
   logic [3:0] req;
   logic [1:0] gnt_idx;
   logic       gnt_valid;
   logic [1:0] ptr;

   int checks = 0;
   int errors = 0;
   bit cmp_en = 0;

   // Model state
   bit m_valid;
   int m_idx;
   int m_ptr;
   int m_cnt;

   rr_arb_4_enc #(.TIMEOUT_CYCLES(T)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .gnt_idx   (gnt_idx),
      .gnt_valid (gnt_valid),
      .ptr       (ptr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
      end
   endtask

   // Behavioural model: a grant lasts until release (or timeout with others
   // waiting); on end the pointer moves past the owner and the first other
   // requester from the pointer onward is served.
   always @(posedge clk or posedge rst) begin
      int  np;
      int  pick;
      bit  stop;
      logic [3:0] oth;
      if (rst) begin
         m_valid <= 0;
         m_idx   <= 0;
         m_ptr   <= 0;
         m_cnt   <= 0;
      end else if (!m_valid) begin
         pick = -1;
         for (int k = 0; k < 4; k++)
            if (pick < 0 && req[(m_ptr + k) % 4]) pick = (m_ptr + k) % 4;
         if (pick >= 0) begin
            m_valid <= 1;
            m_idx   <= pick;
            m_cnt   <= 0;
         end
      end else begin
         oth = req;
         oth[m_idx] = 1'b0;
         stop = !req[m_idx];
`ifdef RR_ARB_TIMEOUT_EN
         if (m_cnt == T - 1 && oth != 0) stop = 1;
`endif
         if (stop) begin
            np = (m_idx + 1) % 4;
            m_ptr <= np;
            pick = -1;
            for (int k = 0; k < 4; k++)
               if (pick < 0 && oth[(np + k) % 4]) pick = (np + k) % 4;
            if (pick >= 0) begin
               m_idx <= pick;
               m_cnt <= 0;
            end else begin
               m_valid <= 0;
            end
         end else if (m_cnt < T - 1) begin
            m_cnt <= m_cnt + 1;
         end
      end
   end

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (cmp_en) begin
         chk("cyc_valid", 32'(gnt_valid), 32'(m_valid));
         chk("cyc_ptr", 32'(ptr), 32'(m_ptr));
         if (m_valid) chk("cyc_idx", 32'(gnt_idx), 32'(m_idx));
      end
   end

   initial begin
      rst = 1'b1;
      req = 4'b0000;
      repeat (3) @(negedge clk);
      chk("rst_valid", 32'(gnt_valid), 0);
      chk("rst_idx", 32'(gnt_idx), 0);
      chk("rst_ptr", 32'(ptr), 0);
      rst = 1'b0;
      cmp_en = 1;

      // Idle with no requests stays idle
      @(negedge clk);
      @(posedge clk); #1;
      chk("idle_valid", 32'(gnt_valid), 0);

      // Single request
      @(negedge clk); req = 4'b0100;
      @(posedge clk); #1;
      chk("single_valid", 32'(gnt_valid), 1);
      chk("single_idx", 32'(gnt_idx), 2);
      @(negedge clk); req = 4'b0000;
      @(posedge clk); #1;
      chk("single_drop_valid", 32'(gnt_valid), 0);
      chk("single_drop_ptr", 32'(ptr), 3);
      chk("idle_hold_idx", 32'(gnt_idx), 2);

      // Wrap from ptr=3
      @(negedge clk); req = 4'b1001;
      @(posedge clk); #1;
      chk("wrap_idx3", 32'(gnt_idx), 3);
      @(negedge clk); req = 4'b0001;
      @(posedge clk); #1;
      chk("wrap_idx0", 32'(gnt_idx), 0);
      chk("wrap_valid", 32'(gnt_valid), 1);
      chk("wrap_ptr", 32'(ptr), 0);

      // Asynchronous reset in the middle of a grant to requester 2
      @(negedge clk); req = 4'b0000;
      @(negedge clk); req = 4'b0100;
      @(posedge clk); #1;
      chk("mid_idx2", 32'(gnt_idx), 2);
      #2 rst = 1'b1;
      #1;
      chk("async_valid", 32'(gnt_valid), 0);
      chk("async_idx", 32'(gnt_idx), 0);
      chk("async_ptr", 32'(ptr), 0);
      @(negedge clk); rst = 1'b0; req = 4'b0000;

      // Rotation with release-and-re-raise after one grant cycle
      @(negedge clk); req = 4'b1111;
      @(posedge clk); #1;
      chk("rot_idx", 32'(gnt_idx), 0);
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk); req = 4'b1111 & ~(4'b0001 << ((i - 1) % 4));
         @(posedge clk); #1;
         chk("rot_idx", 32'(gnt_idx), 32'(i % 4));
         chk("rot_valid", 32'(gnt_valid), 1);
      end

      // Two requesters held continuously (timeout alternation or indefinite hold)
      @(negedge clk); rst = 1'b1; req = 4'b0000;
      @(negedge clk); rst = 1'b0; req = 4'b0011;
      for (int i = 0; i < 24; i++) begin
         @(posedge clk); #1;
`ifdef RR_ARB_TIMEOUT_EN
         chk("hold2_idx", 32'(gnt_idx), 32'((i / T) % 2));
`else
         chk("hold2_idx", 32'(gnt_idx), 0);
`endif
         chk("hold2_valid", 32'(gnt_valid), 1);
      end

      // Lone requester: held throughout, no valid drop
      @(negedge clk); req = 4'b0001;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         chk("sat_idx", 32'(gnt_idx), 0);
         chk("sat_valid", 32'(gnt_valid), 1);
      end

      // Randomized traffic with occasional resets
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (rst) rst = 1'b0;
         else if ($urandom_range(0, 99) == 0) rst = 1'b1;
         if ($urandom_range(0, 2) == 0) req = 4'($urandom);
      end

      @(negedge clk);
      cmp_en = 0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
